// File: rtl/adc_seq_pkg.sv
// Shared types and constants for the ADC scan sequencer.
// State codes are plain constants so legacy code can compare them directly.
package adc_seq_pkg;

   localparam int CH_W      = 4;
   localparam int SAMPLE_W  = 10;
   localparam int NUM_CH    = 16;
   localparam int AVG_SHIFT = 2;
   localparam int ACC_W     = 12;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE    = 3'd0;
   localparam state_t ST_SELECT  = 3'd1;
   localparam state_t ST_DISCARD = 3'd2;
   localparam state_t ST_CAPTURE = 3'd3;
   localparam state_t ST_EMIT    = 3'd4;

   // Index of the highest set bit; identifies the last channel of a pass.
   function automatic logic [CH_W-1:0] highest_set(input logic [NUM_CH-1:0] mask);
      logic [CH_W-1:0] h;
      h = {CH_W{1'b0}};
      for (int i = 0; i < NUM_CH; i++) begin
         h = mask[i] ? CH_W'(i) : h;
      end
      return h;
   endfunction

endpackage

// File: rtl/adc_next_channel.sv
// Rotating priority finder: lowest set mask bit strictly above ptr, wrapping
// through bit 0 and finally back to ptr itself.
module adc_next_channel
   import adc_seq_pkg::*;
(
   input  logic [NUM_CH-1:0] mask,
   input  logic [CH_W-1:0]   ptr,
   output logic [CH_W-1:0]   next_ch,
   output logic              found
);

   logic [CH_W-1:0] idx_s;

   // Walk offsets from farthest to nearest so the nearest hit is written last.
   always_comb begin
      next_ch = {CH_W{1'b0}};
      found   = 1'b0;
      idx_s   = {CH_W{1'b0}};
      for (int i = NUM_CH; i >= 1; i--) begin
         idx_s   = ptr + CH_W'(i);
         found   = found | mask[idx_s];
         next_ch = mask[idx_s] ? idx_s : next_ch;
      end
   end

endmodule

// File: rtl/adc_scan_sequencer.sv
// Round-robin ADC channel scanner with settle discard, timeout and result strobe.
// Build option: define AVERAGE_EN to average four captured samples per channel.
module adc_scan_sequencer
   import adc_seq_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 50000,
   parameter int DISCARD        = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                enable,
   input  logic [NUM_CH-1:0]   ch_mask,
   output logic [CH_W-1:0]     channel,
   input  logic                new_sample,
   input  logic [SAMPLE_W-1:0] sample,
   input  logic [CH_W-1:0]     sample_channel,
   output logic                result_valid,
   output logic [CH_W-1:0]     result_channel,
   output logic [SAMPLE_W-1:0] result_value,
   output logic                scan_done,
   output logic                timeout_err,
   input  logic                clr_err
);

   localparam int                TMO_W     = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
   localparam int                DISC_W    = (DISCARD > 1) ? $clog2(DISCARD) : 1;
   localparam logic [DISC_W-1:0] DISC_LAST = DISC_W'((DISCARD > 0) ? DISCARD - 1 : 0);
   localparam state_t            ST_FIRST  = (DISCARD == 0) ? ST_CAPTURE : ST_DISCARD;

   state_t              state_r;
   logic [CH_W-1:0]     ptr_r;
   logic [CH_W-1:0]     channel_r;
   logic                last_r;
   logic [DISC_W-1:0]   disc_cnt_r;
   logic [TMO_W-1:0]    tmo_cnt_r;
   logic                result_valid_r;
   logic [CH_W-1:0]     result_channel_r;
   logic [SAMPLE_W-1:0] result_value_r;
   logic                scan_done_r;
   logic                timeout_err_r;
   logic [CH_W-1:0]     next_ch_s;
   logic                found_s;
   logic                match_s;
   logic                tmo_hit_s;
`ifdef AVERAGE_EN
   logic [ACC_W-1:0]     acc_r;
   logic [AVG_SHIFT-1:0] avg_cnt_r;
   logic [ACC_W-1:0]     acc_sum_s;

   assign acc_sum_s = acc_r + {{(ACC_W - SAMPLE_W){1'b0}}, sample};
`endif

   adc_next_channel u_next (
      .mask    (ch_mask),
      .ptr     (ptr_r),
      .next_ch (next_ch_s),
      .found   (found_s)
   );

   assign match_s   = new_sample && (sample_channel == channel_r);
   assign tmo_hit_s = (tmo_cnt_r == TMO_LAST);

   assign channel        = channel_r;
   assign result_valid   = result_valid_r;
   assign result_channel = result_channel_r;
   assign result_value   = result_value_r;
   assign scan_done      = scan_done_r;
   assign timeout_err    = timeout_err_r;

   // Scan FSM; EMIT is the result-strobe cycle and performs the next selection.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r          <= ST_IDLE;
         ptr_r            <= {CH_W{1'b1}};
         channel_r        <= {CH_W{1'b0}};
         last_r           <= 1'b0;
         disc_cnt_r       <= {DISC_W{1'b0}};
         tmo_cnt_r        <= {TMO_W{1'b0}};
         result_valid_r   <= 1'b0;
         result_channel_r <= {CH_W{1'b0}};
         result_value_r   <= {SAMPLE_W{1'b0}};
         scan_done_r      <= 1'b0;
         timeout_err_r    <= 1'b0;
`ifdef AVERAGE_EN
         acc_r            <= {ACC_W{1'b0}};
         avg_cnt_r        <= {AVG_SHIFT{1'b0}};
`endif
      end else begin
         result_valid_r <= 1'b0;
         scan_done_r    <= 1'b0;
         // A timeout later in this block overrides the clear.
         if (clr_err) begin
            timeout_err_r <= 1'b0;
         end
         if (!enable) begin
            state_r <= ST_IDLE;
         end else begin
            case (state_r)
               ST_IDLE: begin
                  if (ch_mask != {NUM_CH{1'b0}}) begin
                     state_r <= ST_SELECT;
                  end
               end
               ST_SELECT, ST_EMIT: begin
                  if (found_s) begin
                     channel_r  <= next_ch_s;
                     ptr_r      <= next_ch_s;
                     last_r     <= (next_ch_s == highest_set(ch_mask));
                     disc_cnt_r <= {DISC_W{1'b0}};
                     tmo_cnt_r  <= {TMO_W{1'b0}};
`ifdef AVERAGE_EN
                     acc_r      <= {ACC_W{1'b0}};
                     avg_cnt_r  <= {AVG_SHIFT{1'b0}};
`endif
                     state_r    <= ST_FIRST;
                  end else begin
                     state_r <= ST_IDLE;
                  end
               end
               ST_DISCARD: begin
                  if (match_s && (disc_cnt_r == DISC_LAST)) begin
                     tmo_cnt_r <= {TMO_W{1'b0}};
                     state_r   <= ST_CAPTURE;
                  end else if (tmo_hit_s) begin
                     timeout_err_r <= 1'b1;
                     state_r       <= ST_SELECT;
                  end else begin
                     tmo_cnt_r <= tmo_cnt_r + 1'b1;
                     if (match_s) begin
                        disc_cnt_r <= disc_cnt_r + 1'b1;
                     end
                  end
               end
               ST_CAPTURE: begin
`ifdef AVERAGE_EN
                  if (match_s && (avg_cnt_r == {AVG_SHIFT{1'b1}})) begin
                     result_valid_r   <= 1'b1;
                     result_channel_r <= channel_r;
                     result_value_r   <= acc_sum_s[ACC_W-1:AVG_SHIFT];
                     scan_done_r      <= last_r;
                     state_r          <= ST_EMIT;
                  end else if (match_s) begin
                     acc_r     <= acc_sum_s;
                     avg_cnt_r <= avg_cnt_r + 1'b1;
                     tmo_cnt_r <= {TMO_W{1'b0}};
                  end else if (tmo_hit_s) begin
                     timeout_err_r <= 1'b1;
                     state_r       <= ST_SELECT;
                  end else begin
                     tmo_cnt_r <= tmo_cnt_r + 1'b1;
                  end
`else
                  if (match_s) begin
                     result_valid_r   <= 1'b1;
                     result_channel_r <= channel_r;
                     result_value_r   <= sample;
                     scan_done_r      <= last_r;
                     state_r          <= ST_EMIT;
                  end else if (tmo_hit_s) begin
                     timeout_err_r <= 1'b1;
                     state_r       <= ST_SELECT;
                  end else begin
                     tmo_cnt_r <= tmo_cnt_r + 1'b1;
                  end
`endif
               end
               default: begin
                  state_r <= ST_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Self-checking bench for adc_scan_sequencer: directed scenarios plus randomized
// scans checked against a transaction-level model of channel order and capture.
module tb_adc_scan_sequencer;

   localparam int TMO  = 100;
   localparam int DISC = 2;
`ifdef AVERAGE_EN
   localparam int CAP_N = 4;
`else
   localparam int CAP_N = 1;
`endif
   localparam int NM = DISC + CAP_N;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        enable = 1'b0;
   logic [15:0] ch_mask = 16'h0000;
   logic [3:0]  channel;
   logic        new_sample = 1'b0;
   logic [9:0]  sample = 10'd0;
   logic [3:0]  sample_channel = 4'd0;
   logic        result_valid;
   logic [3:0]  result_channel;
   logic [9:0]  result_value;
   logic        scan_done;
   logic        timeout_err;
   logic        clr_err = 1'b0;

   adc_scan_sequencer #(.TIMEOUT_CYCLES(TMO), .DISCARD(DISC)) dut (
      .clk(clk), .rst(rst), .enable(enable), .ch_mask(ch_mask), .channel(channel),
      .new_sample(new_sample), .sample(sample), .sample_channel(sample_channel),
      .result_valid(result_valid), .result_channel(result_channel),
      .result_value(result_value), .scan_done(scan_done),
      .timeout_err(timeout_err), .clr_err(clr_err)
   );

   always #5 clk = ~clk;

   int         n_vec = 0;
   int         n_err = 0;
   logic [9:0] vals[NM];
   int         early_rv;
   logic       obs_rv, obs_done;
   logic [3:0] obs_ch;
   logic [9:0] obs_val;

   // ---------------- reference model ----------------
   function automatic logic [3:0] model_next(input logic [15:0] m, input logic [3:0] p);
      int q[$];
      for (int c = 0; c < 16; c++) if (m[c]) q.push_back(c);
      foreach (q[i]) if (q[i] > int'(p)) return 4'(q[i]);
      return 4'(q[0]);
   endfunction

   function automatic logic [3:0] model_last(input logic [15:0] m);
      int h = 0;
      for (int c = 0; c < 16; c++) if (m[c]) h = c;
      return 4'(h);
   endfunction

   function automatic logic [9:0] exp_value();
      int s = 0;
      for (int k = DISC; k < NM; k++) s += int'(vals[k]);
      return 10'(s / CAP_N);
   endfunction

   // ---------------- stimulus helpers (no checking) ----------------
   task automatic tick();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1; enable = 1'b0; new_sample = 1'b0; clr_err = 1'b0;
      tick(); tick();
      rst = 1'b0;
   endtask

   task automatic fill_random();
      for (int k = 0; k < NM; k++) vals[k] = 10'($urandom);
   endtask

   task automatic noise(input logic [3:0] ch);
      new_sample     = 1'($urandom_range(0, 1));
      sample_channel = ch ^ 4'($urandom_range(1, 15));
      sample         = 10'($urandom);
   endtask

   // Feeds DISC+CAP_N matching strobes with non-matching noise in between and
   // records what appears one cycle after the final strobe.
   task automatic feed_visit(input logic [3:0] ch);
      int gaps;
      early_rv = 0;
      for (int k = 0; k < NM; k++) begin
         gaps = $urandom_range(0, 2);
         for (int g = 0; g < gaps; g++) begin
            noise(ch); tick();
            if (result_valid) early_rv++;
         end
         new_sample = 1'b1; sample_channel = ch; sample = vals[k];
         tick();
         if (k < NM - 1 && result_valid) early_rv++;
      end
      obs_rv = result_valid; obs_ch = result_channel; obs_val = result_value; obs_done = scan_done;
      new_sample = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      do_reset();
      n_vec++;
      if (channel !== 4'd0) begin n_err++; $display("FAIL reset_channel: got %0d want 0", channel); end
      n_vec++;
      if ({result_valid, result_channel, result_value, scan_done, timeout_err} !== 17'd0) begin
         n_err++;
         $display("FAIL reset_outputs: got rv=%0b ch=%0d val=%0d done=%0b err=%0b want all 0",
                  result_valid, result_channel, result_value, scan_done, timeout_err);
      end
   endtask

   task automatic test_single_channel();
      do_reset();
      ch_mask = 16'h0001; enable = 1'b1;
      tick(); tick();
`ifdef AVERAGE_EN
      vals[0] = 10'd100; vals[1] = 10'd200; vals[2] = 10'd1023;
      vals[3] = 10'd1022; vals[4] = 10'd1021; vals[5] = 10'd1021;
`else
      vals[0] = 10'd100; vals[1] = 10'd200; vals[2] = 10'd300;
`endif
      for (int pass = 0; pass < 2; pass++) begin
         feed_visit(4'd0);
         n_vec++;
         if (early_rv !== 0) begin n_err++; $display("FAIL single_early: got %0d early pulses want 0", early_rv); end
         n_vec++;
         if ({obs_rv, obs_ch, obs_done} !== {1'b1, 4'd0, 1'b1}) begin
            n_err++; $display("FAIL single_result: got rv=%0b ch=%0d done=%0b want 1/0/1", obs_rv, obs_ch, obs_done);
         end
         n_vec++;
         if (obs_val !== exp_value()) begin n_err++; $display("FAIL single_value: got %0d want %0d", obs_val, exp_value()); end
         tick();
         n_vec++;
         if (result_valid !== 1'b0 || channel !== 4'd0) begin
            n_err++; $display("FAIL single_pulse: got rv=%0b ch=%0d want 0/0", result_valid, channel);
         end
         fill_random();
      end
   endtask

   task automatic test_scan_order();
      logic [3:0] exp_ch, last_ch;
      logic [3:0] exp_seq[4];
      exp_seq[0] = 4'd0; exp_seq[1] = 4'd2; exp_seq[2] = 4'd5; exp_seq[3] = 4'd0;
      do_reset();
      ch_mask = 16'h0025; enable = 1'b1;
      tick(); tick();
      exp_ch  = model_next(ch_mask, 4'hF);
      last_ch = model_last(ch_mask);
      for (int v = 0; v < 4; v++) begin
         n_vec++;
         if (channel !== exp_seq[v] || channel !== exp_ch) begin
            n_err++; $display("FAIL scan_channel[%0d]: got %0d want %0d", v, channel, exp_seq[v]);
         end
         fill_random();
         feed_visit(exp_ch);
         n_vec++;
         if ({early_rv == 0, obs_rv, obs_ch, obs_val, obs_done} !==
             {1'b1, 1'b1, exp_ch, exp_value(), exp_ch == last_ch}) begin
            n_err++;
            $display("FAIL scan_result[%0d]: got early=%0d rv=%0b ch=%0d val=%0d done=%0b want 0/1/%0d/%0d/%0b",
                     v, early_rv, obs_rv, obs_ch, obs_val, obs_done, exp_ch, exp_value(), exp_ch == last_ch);
         end
         n_vec++;
         if (channel !== exp_ch) begin n_err++; $display("FAIL scan_hold[%0d]: got %0d want %0d", v, channel, exp_ch); end
         exp_ch = model_next(ch_mask, exp_ch);
         tick();
      end
   endtask

   task automatic test_timeout();
      int bad_rv = 0;
      do_reset();
      ch_mask = 16'h0003; enable = 1'b1;
      for (int t = 1; t <= 204; t++) begin
         new_sample = 1'($urandom_range(0, 1)); sample_channel = 4'd3; sample = 10'($urandom);
         if (t == 104) clr_err = 1'b1;
         if (t == 204) clr_err = 1'b0;
         tick();
         if (result_valid || scan_done) bad_rv++;
         if (t == 101) begin
            n_vec++;
            if ({timeout_err, channel} !== {1'b0, 4'd0}) begin
               n_err++; $display("FAIL tmo_before: got err=%0b ch=%0d want 0/0", timeout_err, channel);
            end
         end else if (t == 102) begin
            n_vec++;
            if ({timeout_err, channel} !== {1'b1, 4'd0}) begin
               n_err++; $display("FAIL tmo_set: got err=%0b ch=%0d want 1/0", timeout_err, channel);
            end
         end else if (t == 103) begin
            n_vec++;
            if (channel !== 4'd1) begin n_err++; $display("FAIL tmo_skip: got ch=%0d want 1", channel); end
         end else if (t == 104 || t == 202) begin
            n_vec++;
            if (timeout_err !== 1'b0) begin n_err++; $display("FAIL tmo_clear@%0d: got %0b want 0", t, timeout_err); end
         end else if (t == 203) begin
            n_vec++;
            if (timeout_err !== 1'b1) begin n_err++; $display("FAIL tmo_set_wins: got %0b want 1", timeout_err); end
         end else if (t == 204) begin
            n_vec++;
            if ({timeout_err, channel} !== {1'b1, 4'd0}) begin
               n_err++; $display("FAIL tmo_wrap: got err=%0b ch=%0d want 1/0", timeout_err, channel);
            end
         end
      end
      new_sample = 1'b0;
      n_vec++;
      if (bad_rv !== 0) begin n_err++; $display("FAIL tmo_no_result: got %0d pulses want 0", bad_rv); end
   endtask

   task automatic test_enable_drop();
      int bad_rv = 0;
      do_reset();
      ch_mask = 16'h000A; enable = 1'b1;
      tick(); tick();
      n_vec++;
      if (channel !== 4'd1) begin n_err++; $display("FAIL en_first: got %0d want 1", channel); end
      new_sample = 1'b1; sample_channel = 4'd1; sample = 10'd55;
      tick();
      enable = 1'b0;
      for (int t = 0; t < 6; t++) begin
         sample = 10'($urandom); tick();
         if (result_valid) bad_rv++;
      end
      new_sample = 1'b0;
      n_vec++;
      if (bad_rv !== 0 || channel !== 4'd1) begin
         n_err++; $display("FAIL en_idle: got pulses=%0d ch=%0d want 0/1", bad_rv, channel);
      end
      enable = 1'b1;
      tick(); tick();
      n_vec++;
      if (channel !== 4'd3) begin n_err++; $display("FAIL en_resume: got %0d want 3", channel); end
      fill_random();
      feed_visit(4'd3);
      n_vec++;
      if ({obs_rv, obs_ch, obs_val, obs_done} !== {1'b1, 4'd3, exp_value(), 1'b1}) begin
         n_err++; $display("FAIL en_result: got rv=%0b ch=%0d val=%0d done=%0b want 1/3/%0d/1",
                           obs_rv, obs_ch, obs_val, obs_done, exp_value());
      end
      enable = 1'b0;
      tick();
      n_vec++;
      if (result_valid !== 1'b0 || channel !== 4'd3) begin
         n_err++; $display("FAIL en_inflight: got rv=%0b ch=%0d want 0/3", result_valid, channel);
      end
      enable = 1'b1;
      tick(); tick();
      for (int k = 0; k < NM - 1; k++) begin
         new_sample = 1'b1; sample_channel = 4'd1; sample = 10'($urandom); tick();
      end
      enable = 1'b0;
      tick();
      new_sample = 1'b0;
      n_vec++;
      if (result_valid !== 1'b0 || channel !== 4'd1) begin
         n_err++; $display("FAIL en_abandon: got rv=%0b ch=%0d want 0/1", result_valid, channel);
      end
   endtask

   task automatic test_rst_mid();
      do_reset();
      ch_mask = 16'h0006; enable = 1'b1;
      tick(); tick();
      fill_random();
      feed_visit(4'd1);
      tick();
      n_vec++;
      if (channel !== 4'd2) begin n_err++; $display("FAIL rst_pre: got ch=%0d want 2", channel); end
      for (int k = 0; k < NM - 1; k++) begin
         new_sample = 1'b1; sample_channel = 4'd2; sample = 10'($urandom); tick();
      end
      rst = 1'b1;
      tick();
      new_sample = 1'b0;
      n_vec++;
      if ({channel, result_valid, result_channel, result_value, scan_done, timeout_err} !== 21'd0) begin
         n_err++; $display("FAIL rst_mid: got ch=%0d rv=%0b rch=%0d val=%0d done=%0b err=%0b want all 0",
                           channel, result_valid, result_channel, result_value, scan_done, timeout_err);
      end
      rst = 1'b0;
      tick(); tick();
      n_vec++;
      if (channel !== 4'd1) begin n_err++; $display("FAIL rst_restart: got %0d want 1", channel); end
   endtask

   task automatic test_random_scan();
      logic [3:0] cur, last_ch;
      do_reset();
      ch_mask = 16'($urandom_range(1, 16'hFFFF)); enable = 1'b1;
      tick(); tick();
      cur     = model_next(ch_mask, 4'hF);
      last_ch = model_last(ch_mask);
      for (int v = 0; v < 30; v++) begin
         n_vec++;
         if (channel !== cur) begin n_err++; $display("FAIL rnd_channel[%0d]: got %0d want %0d", v, channel, cur); end
         fill_random();
         feed_visit(cur);
         n_vec++;
         if ({early_rv == 0, obs_rv, obs_ch, obs_val, obs_done} !==
             {1'b1, 1'b1, cur, exp_value(), cur == last_ch}) begin
            n_err++;
            $display("FAIL rnd_result[%0d]: got early=%0d rv=%0b ch=%0d val=%0d done=%0b want 0/1/%0d/%0d/%0b",
                     v, early_rv, obs_rv, obs_ch, obs_val, obs_done, cur, exp_value(), cur == last_ch);
         end
         if ($urandom_range(0, 2) == 0) ch_mask = 16'($urandom_range(1, 16'hFFFF));
         cur     = model_next(ch_mask, cur);
         last_ch = model_last(ch_mask);
         tick();
      end
   endtask

   initial begin
      tick();
      test_reset();
      test_single_channel();
      test_scan_order();
      test_timeout();
      test_enable_drop();
      test_rst_mid();
      test_random_scan();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached before summary");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/adc_scan_sequencer.md
Name: adc_scan_sequencer

Overview:
Schedules the shared AVR ADC between up to 16 analog inputs. It drives the channel select into the AVR interface, discards stale samples after each channel switch, and captures one qualified sample per enabled channel. Each capture is emitted as a one-cycle result strobe that downstream logic can use, e.g. the PWM compare register or the phased-delay tap configuration. Sits between the AVR interface and all sample consumers, at the 50 MHz system clock.

Parameters:
TIMEOUT_CYCLES, 50000, max cycles to wait for a matching sample before abandoning a channel (1 ms at 50 MHz).
DISCARD, 2, matching samples dropped after each channel switch (ADC mux settling); 0 allowed.

Ports:
clk  input  1  system clock, 50 MHz, all logic on rising edge
rst  input  1  synchronous, active-high reset
enable  input  1  scan run/stop
ch_mask  input  16  bit n set = channel n scanned; sampled only in SELECT
channel  output  4  channel select to AVR interface
new_sample  input  1  AVR interface sample strobe
sample  input  10  AVR interface sample value
sample_channel  input  4  channel tag of sample
result_valid  output  1  one-cycle strobe, result fields valid
result_channel  output  4  channel of result
result_value  output  10  captured (or averaged) value
scan_done  output  1  one-cycle strobe with last result of a pass
timeout_err  output  1  sticky: some channel timed out
clr_err  input  1  clears timeout_err

Behaviour:
- Reset: state IDLE; channel=0; result_valid=0; result_channel=0; result_value=0; scan_done=0; timeout_err=0; search pointer=15, so the first pass starts at ch 0.
- A sample "matches" when new_sample=1 and sample_channel==channel. Non-matching samples are ignored and not counted.
- IDLE: if enable=1 and ch_mask!=0, go to SELECT. Otherwise stay.
- SELECT (1 cycle):
  - Pick the lowest set mask bit strictly above the pointer, wrapping to bit 0.
  - Load channel and pointer; clear the discard counter and timeout counter.
  - Go to DISCARD, or to CAPTURE if DISCARD=0.
  - If the mask is now 0, go to IDLE.
- DISCARD: count matches. On the DISCARD-th match go to CAPTURE and reset the timeout counter.
- CAPTURE: on a match, latch the value. Next cycle: result_valid=1 with channel/value, then go to SELECT.
  - Latency: result_valid is asserted 1 cycle after the accepted new_sample.
- scan_done asserts together with result_valid when the emitted channel is the highest set bit of the mask latched at SELECT.
- Timeout:
  - Counter runs in DISCARD/CAPTURE and restarts on every state entry.
  - Reaching TIMEOUT_CYCLES-1: set timeout_err, emit no result, go to SELECT (channel skipped).
  - scan_done does not assert for a skipped channel.
- timeout_err:
  - clr_err clears it.
  - A set and a clear in the same cycle: set wins.
- enable dropped in any state: go to IDLE next cycle.
  - The partial capture is abandoned and no result is emitted.
  - A result_valid pulse already in flight still completes.
  - Pointer and channel are held.
- ch_mask changes take effect at the next SELECT only.
- Single-channel mask: the same channel is reselected every pass; DISCARD still applies per pass.
- rst mid-operation: everything returns to reset values in the same edge; no pulse emitted.

Optional Feature:
AVERAGE_EN:
- Defined: CAPTURE accepts 4 matches into a 12-bit accumulator; result_value = acc[11:2] (truncating). The timeout counter restarts after each accepted match.
- Undefined: single-sample capture as above; no accumulator is synthesized.

Decomposition:
- Package adc_seq_pkg holds:
  - state enum (IDLE, SELECT, DISCARD, CAPTURE, EMIT)
  - CH_W=4, SAMPLE_W=10, NUM_CH=16
  - AVG_SHIFT=2, ACC_W=12
- One sub-module is natural: adc_next_channel, a combinational rotate-priority finder taking mask and pointer and returning next channel plus found flag. It is reused by any future ADC arbiter.

Test Plan:
1. ch_mask=16'h0001, DISCARD=2, send ch0 samples 100, 200, 300 -> only 300 emitted: result_valid one cycle after the third strobe, result_channel=0, result_value=300, scan_done=1.
2. ch_mask=16'h0025, feed each selected channel in turn -> channel sequence 0, 2, 5, 0; scan_done only with ch5; channel output changes one cycle after each result_valid.
3. Mask 16'h0003 with sample_channel=3 traffic only, TIMEOUT_CYCLES=100 -> no results; timeout_err=1 after 100 cycles on ch0, then channel=1; clr_err then drops timeout_err.
4. Drop enable mid-DISCARD, then re-enable -> no result emitted, IDLE→SELECT moves to the next channel after the held pointer.
5. rst asserted mid-CAPTURE with new_sample in the same cycle -> all outputs 0 next cycle, no result_valid; after release, the scan restarts at the lowest set channel.
6. AVERAGE_EN, ch0 samples 1023, 1022, 1021, 1021 after discard -> result_value=1021 (4087>>2).
